dmem_access_unit: RTL

Memory-stage responder for the load/store control signals `mem_read` and `mem_write` produced by instruction decode in the RV32IM pipeline. It captures each load or store issued by the EX/MEM stage and runs a req/ack handshake with the data-memory bus. It generates byte enables and lane-aligned store data, and returns sign- or zero-extended load data. While an access is outstanding it holds the pipeline stalled through `busy`.

---
 rtl/rv32_mem_pkg.sv | 26 ++
 rtl/load_store_align.sv | 41 ++++
 rtl/dmem_access_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the RV32 data-memory stage: funct3 access codes,
// the access-unit FSM state type and the alignment check used by the trap build.
package rv32_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } dmem_state_t;

    // Undefined funct3 codes behave as word accesses, so they need a word-aligned address.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_B, F3_BU: is_misaligned = 1'b0;
            F3_H, F3_HU: is_misaligned = lo[0];
            default:     is_misaligned = |lo;
        endcase
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational lane steering: byte enables and replicated store data for the bus,
// and lane selection plus sign/zero extension for load data.
module load_store_align
    import rv32_mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] store_data,
    input  logic [31:0] bus_word,
    output logic [3:0]  byte_en,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign rd_byte = bus_word[{addr_lo, 3'b000} +: 8];
    assign rd_half = addr_lo[1] ? bus_word[31:16] : bus_word[15:0];

    always_comb begin
        byte_en    = 4'b1111;
        lane_wdata = store_data;
        load_data  = bus_word;
        case (funct3)
            F3_B, F3_BU: begin
                byte_en    = 4'b0001 << addr_lo;
                lane_wdata = {4{store_data[7:0]}};
                load_data  = (funct3 == F3_B) ? {{24{rd_byte[7]}}, rd_byte} : {24'd0, rd_byte};
            end
            F3_H, F3_HU: begin
                // Halfword lane comes from addr[1] only; addr[0] is not used here.
                byte_en    = 4'b0011 << {addr_lo[1], 1'b0};
                lane_wdata = {2{store_data[15:0]}};
                load_data  = (funct3 == F3_H) ? {{16{rd_half[15]}}, rd_half} : {16'd0, rd_half};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// Memory-stage load/store responder: captures one access, runs a req/ack bus handshake
// and stalls the pipeline meanwhile. DMEM_MISALIGN_TRAP_EN adds a misaligned-access fault.
module dmem_access_unit
    import rv32_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        busy,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    output logic        misaligned_fault
`endif
);

    dmem_state_t state, next_state;

    logic        req_any;
    logic        mis;
    logic [1:0]  addr_lo_q;
    logic [2:0]  f3_q;
    logic        is_store_q;
    logic [1:0]  sel_lo;
    logic [2:0]  sel_f3;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;

    assign req_any = mem_read | mem_write;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign mis = is_misaligned(funct3, address[1:0]);
`else
    assign mis = 1'b0;
`endif

    // One aligner serves both paths: live inputs while idle (store setup), captured ones after.
    assign sel_lo = (state == IDLE) ? address[1:0] : addr_lo_q;
    assign sel_f3 = (state == IDLE) ? funct3 : f3_q;

    load_store_align u_align (
        .addr_lo    (sel_lo),
        .funct3     (sel_f3),
        .store_data (write_data),
        .bus_word   (bus_rdata),
        .byte_en    (al_be),
        .lane_wdata (al_wdata),
        .load_data  (al_rdata)
    );

    assign busy = rst_n & (((state == IDLE) & req_any) | (state == ACCESS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_any) next_state = mis ? DONE : ACCESS;
            ACCESS:  if (bus_ack) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_be     <= '0;
            read_data  <= '0;
            addr_lo_q  <= '0;
            f3_q       <= '0;
            is_store_q <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
            misaligned_fault <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (req_any) begin
                    addr_lo_q  <= address[1:0];
                    f3_q       <= funct3;
                    is_store_q <= mem_write;
                    if (mis) begin
                        read_data <= '0;
`ifdef DMEM_MISALIGN_TRAP_EN
                        misaligned_fault <= 1'b1;
`endif
                    end else begin
                        bus_req   <= 1'b1;
                        bus_we    <= mem_write;
                        bus_addr  <= {address[31:2], 2'b00};
                        bus_be    <= al_be;
                        bus_wdata <= al_wdata;
                    end
                end
                ACCESS: if (bus_ack) begin
                    bus_req <= 1'b0;
                    bus_we  <= 1'b0;
                    if (!is_store_q) read_data <= al_rdata;
                end
                DONE: begin
`ifdef DMEM_MISALIGN_TRAP_EN
                    misaligned_fault <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
